// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer: multi-cycle WIDTH-bit adder built around a 4-bit
// carry-lookahead stage. Operands are accepted on a valid/ready handshake,
// then one 4-bit slice per cycle (LSB first) passes through the lookahead
// logic, with C4 rippling into the next slice's C0 through a register.
// The result (sum, cout, ovf) is returned on a second valid/ready handshake.
//
// Build option: define CLA_SEQ_OVF_EN to compute the signed overflow flag.
// Without it, ovf is tied to 0 and no overflow logic is generated.
module cla_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICES = WIDTH / 4;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;

  // Slice views of the operand registers, selected by idx_reg.
  logic [3:0] a_slice [SLICES];
  logic [3:0] b_slice [SLICES];

  genvar gi;
  generate
    for (gi = 0; gi < SLICES; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[4*gi +: 4];
      assign b_slice[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  // 4-bit carry-lookahead stage (purely combinational, no pipeline register).
  logic [3:0] cla_a;
  logic [3:0] cla_b;
  logic       cla_c0;
  logic [3:0] cla_g;
  logic [3:0] cla_p;
  logic [4:0] cla_c;
  logic [3:0] cla_f;

  assign cla_a  = a_slice[idx_reg];
  assign cla_b  = b_slice[idx_reg];
  assign cla_c0 = carry_reg;
  assign cla_g  = cla_a & cla_b;
  assign cla_p  = cla_a ^ cla_b;

  // Every carry is a flat sum of generate/propagate terms, not a ripple.
  assign cla_c[0] = cla_c0;
  assign cla_c[1] = cla_g[0] | (cla_p[0] & cla_c0);
  assign cla_c[2] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & cla_c0);
  assign cla_c[3] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
                  | (cla_p[2] & cla_p[1] & cla_p[0] & cla_c0);
  assign cla_c[4] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
                  | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
                  | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & cla_c0);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum_bit
      assign cla_f[gi] = cla_p[gi] ^ cla_c[gi];
    end
  endgenerate

`ifdef CLA_SEQ_OVF_EN
  logic ovf_reg;
  // Signed overflow: operands share a sign but the top result bit differs.
  logic ovf_next;
  assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_f[3] != a_reg[WIDTH-1]);
  assign ovf      = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  // Sequencer FSM: accept operands, walk the slices, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg[4*idx_reg +: 4] <= cla_f;
          carry_reg               <= cla_c[4];
          if (idx_reg == IDX_W'(SLICES - 1)) begin
            // Last slice: idx stays put so it never wraps.
            cout_reg  <= cla_c[4];
            state_reg <= DONE;
`ifdef CLA_SEQ_OVF_EN
            ovf_reg   <= ovf_next;
`endif
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Testbench for cla_slice_sequencer: directed cases plus randomized
// transactions, checked against a plain-arithmetic reference model.
module tb_cla_slice_sequencer;

  localparam int WIDTH  = 16;
  localparam int SLICES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  cla_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer addition.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic mc);
    logic [WIDTH:0] full;
    logic           mo;
    full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
    mo   = 1'b0;
`ifdef CLA_SEQ_OVF_EN
    mo = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
`endif
    return {mo, full};
  endfunction

  // One full transaction; hold = DONE cycles with out_ready low while
  // the input side is scrambled.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, input int hold, output logic [WIDTH-1:0] got);
    logic [WIDTH+1:0] exp;
    int n;
    exp = model(ta, tb, tc);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check("latency", n, SLICES + 1);
    check("sum", sum, exp[WIDTH-1:0]);
    check("cout", cout, exp[WIDTH]);
    check("ovf", ovf, exp[WIDTH+1]);
    got = sum;
    for (int i = 0; i < hold; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, exp[WIDTH-1:0]);
      check("hold_cout", cout, exp[WIDTH]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    $display("txn a=%h b=%h cin=%0d sum=%h cout=%0d ovf=%0d", ta, tb, tc, sum, cout, ovf);
  endtask

  logic [WIDTH-1:0]  got;
  logic [WIDTH+1:0]  exp_q[$];
  logic [WIDTH+1:0]  e;
  int                last_acc;
  int                cyc;

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0, got);
    check("wrap_sum_lit", got, 16'h0000);
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0, got);
    check("ovf_sum_lit", got, 16'h8000);
    run_txn(16'h1234, 16'h4321, 1'b1, 0, got);
    check("cin_sum_lit", got, 16'h5556);
    run_txn(16'h00FF, 16'h0F01, 1'b0, 0, got);
    check("chain_sum_lit", got, 16'h1000);

    // Backpressure, then no stray capture afterwards
    run_txn(16'hA5A5, 16'h1357, 1'b1, 5, got);
    for (int i = 0; i < SLICES + 2; i++) begin
      @(negedge clk);
      check("bp_no_capture", out_valid, 0);
    end

    // Reset in the second RUN cycle
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_ovf", ovf, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SLICES + 2; i++) begin
      @(negedge clk);
      check("arst_no_result", out_valid, 0);
    end
    run_txn(16'h0003, 16'h0004, 1'b0, 0, got);
    check("after_rst_lit", got, 16'h0007);

    // Random transactions with random backpressure
    for (int t = 0; t < 12; t++) begin
      run_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 2)), got);
    end

    // Back-to-back streaming
    @(negedge clk);
    last_acc  = -1;
    out_ready = 1'b1;
    for (cyc = 0; cyc < 100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("b2b_sum", sum, e[WIDTH-1:0]);
          check("b2b_cout", cout, e[WIDTH]);
          check("b2b_ovf", ovf, e[WIDTH+1]);
          $display("txn b2b sum=%h cout=%0d ovf=%0d", sum, cout, ovf);
        end
      end
      if (cyc < 60) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        if (in_ready) begin
          if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, SLICES + 2);
          last_acc = cyc;
          exp_q.push_back(model(a, b, cin));
        end
      end else begin
        in_valid = 1'b0;
        if (exp_q.size() == 0) break;
      end
    end
    check("b2b_drained", exp_q.size(), 0);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
